// File: rtl/mb_pkg.sv
`timescale 1ns/1ps
// mb_pkg: shared constants, flit type and Gray-code helpers for the mainband receiver
package mb_pkg;
  localparam int FLIT_BYTES = 64;
  localparam int MB_LANES = 16;
  localparam int UI_PER_FLIT = 32;
  localparam int FLIT_BITS = FLIT_BYTES * 8;
  typedef logic [7:0] flit_t [FLIT_BYTES-1:0];
  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/mb_rx_flit_fifo.sv
`timescale 1ns/1ps
// mb_rx_flit_fifo: whole-flit async FIFO, written on the capture strobe, read on clk
module mb_rx_flit_fifo
  import mb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = FLIT_BITS
) (
  input  logic         reset,
  input  logic         wclk,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         clk,
  output logic         rd_ok,
  output logic [W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // Gray pointers differ only in their two top bits when the write side is one lap ahead
  localparam logic [PW-1:0] FULL_X = PW'(3) << (PW - 2);
  logic [PW-1:0] wbin, wgray, wnext, rbin, rgray, rnext, rq1, rq2, wq1, wq2;
  logic [W-1:0] mem [DEPTH];
  logic full, wr_go;
  assign wnext = wbin + PW'(1);
  assign rnext = rbin + PW'(1);
  assign full = (wgray ^ rq2) == FULL_X;
  assign wr_go = wr_en && !full;
  assign rd_ok = rgray != wq2;
  assign rd_data = mem[rbin[AW-1:0]];
  // write pointer advance and read pointer synchroniser, strobe domain
  always_ff @(posedge wclk or negedge reset)
    if (!reset) {wbin, wgray, rq1, rq2} <= '0;
    else begin
      {rq2, rq1} <= {rq1, rgray};
      if (wr_go) begin
        wbin <= wnext;
        wgray <= PW'(bin2gray(8'(wnext)));
      end
    end
  // flit storage; a full FIFO drops the incoming flit rather than overwrite
  always_ff @(posedge wclk)
    if (wr_go) mem[wbin[AW-1:0]] <= wr_data;
  // read pointer advance and write pointer synchroniser, clk domain
  always_ff @(posedge clk or negedge reset)
    if (!reset) {rbin, rgray, wq1, wq2} <= '0;
    else begin
      {wq2, wq1} <= {wq1, wgray};
      if (rd_ok) begin
        rbin <= rnext;
        rgray <= PW'(bin2gray(8'(rnext)));
      end
    end
endmodule

// File: rtl/mb_rx.sv
`timescale 1ns/1ps
// mb_rx: mainband receiver, DDR flit capture from 16 lanes and handoff to clk
module mb_rx
  import mb_pkg::*;
#(
  parameter int flit_buffer_size = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_iPin,
  input  logic [1:0]          periph_clkPins_i,
  input  logic [MB_LANES-1:0] dataPins_i,
  output logic                valid_o,
  output flit_t               data_o
);
  logic strobe, unused_clk_n;
  logic neg_v;
  logic [MB_LANES-1:0] neg_d;
  logic [4:0] ui, ui_a, ui_b;
  logic [FLIT_BITS-1:0] sh, sh_a, sh_b, rd_data;
  logic done_a, done_b, rd_ok;
  assign strobe = periph_clkPins_i[0];
  assign unused_clk_n = periph_clkPins_i[1];
  // the falling-edge UI is parked here and folded in at the following rising edge
  always_ff @(negedge strobe or negedge reset)
    if (!reset) {neg_v, neg_d} <= '0;
    else {neg_v, neg_d} <= {valid_iPin, dataPins_i};
  // two UIs per rising edge: the parked falling-edge UI first, then the current one;
  // new lanes shift in at the top so UI 0 ends up in bits [15:0] after 32 shifts
  assign sh_a = neg_v ? {neg_d, sh[FLIT_BITS-1:MB_LANES]} : sh;
  assign ui_a = neg_v ? ui + 5'd1 : 5'd0;
  assign done_a = neg_v && ui == 5'd31;
  assign sh_b = valid_iPin ? {dataPins_i, sh_a[FLIT_BITS-1:MB_LANES]} : sh_a;
  assign ui_b = valid_iPin ? ui_a + 5'd1 : 5'd0;
  assign done_b = valid_iPin && ui_a == 5'd31;
  // UI counter and shift register advance on the rising strobe edge
  always_ff @(posedge strobe or negedge reset)
    if (!reset) {ui, sh} <= '0;
    else {ui, sh} <= {ui_b, sh_b};
  mb_rx_flit_fifo #(.DEPTH(flit_buffer_size), .W(FLIT_BITS)) u_fifo (
    .reset(reset),
    .wclk(strobe),
    .wr_en(done_a || done_b),
    .wr_data(done_b ? sh_b : sh_a),
    .clk(clk),
    .rd_ok(rd_ok),
    .rd_data(rd_data)
  );
  // output register: one pulse per popped flit, data held between reads
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid_o <= 1'b0;
      for (int i = 0; i < FLIT_BYTES; i++) data_o[i] <= 8'h00;
    end else begin
      valid_o <= rd_ok;
      if (rd_ok) for (int i = 0; i < FLIT_BYTES; i++) data_o[i] <= rd_data[8*i +: 8];
    end
endmodule

// File: tb/tb_mb_rx.sv
`timescale 1ns/1ps
// tb_mb_rx: scoreboard bench for the mainband receiver
module tb_mb_rx;
  import mb_pkg::*;
  localparam int DEPTH = 4;
  logic clk, reset, valid_iPin, run;
  logic [1:0] periph_clkPins_i;
  logic [15:0] dataPins_i;
  logic valid_o;
  flit_t data_o;
  logic [511:0] expq[$];
  int checks = 0, errors = 0, pulses = 0, nflit = 0;

  mb_rx #(.flit_buffer_size(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .valid_iPin(valid_iPin),
    .periph_clkPins_i(periph_clkPins_i),
    .dataPins_i(dataPins_i),
    .valid_o(valid_o),
    .data_o(data_o)
  );

  initial begin
    clk = 1'b0;
    run = 1'b1;
    forever begin
      #5;
      clk = run ? ~clk : 1'b0;
    end
  end

  function automatic logic [511:0] packed_out();
    logic [511:0] p;
    for (int i = 0; i < 64; i++) p[8*i +: 8] = data_o[i];
    return p;
  endfunction

  function automatic logic [511:0] str_flit(input string s);
    logic [511:0] f;
    for (int i = 0; i < 64; i++) f[8*i +: 8] = (i < s.len()) ? 8'(s[i]) : 8'h20;
    return f;
  endfunction

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  // monitor: pop the oldest expected flit on every valid_o pulse
  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      logic [511:0] got, want;
      pulses++;
      checks++;
      got = packed_out();
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got %h required no pulse", got);
      end else begin
        want = expq.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL flit%0d: got %h required %h", nflit, got, want);
        end
        nflit++;
      end
    end
  end

  task automatic ui(input logic v, input logic [15:0] d);
    valid_iPin = v;
    dataPins_i = d;
    #0.125;
    periph_clkPins_i = ~periph_clkPins_i;
    #0.125;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) ui(1'b0, 16'h0000);
  endtask

  task automatic send(input logic [511:0] f, input bit expect_out);
    for (int u = 0; u < 32; u++) ui(1'b1, f[16*u +: 16]);
    if (expect_out) expq.push_back(f);
  endtask

  task automatic drain(input string name, input int want);
    for (int i = 0; i < 400 && expq.size() != 0; i++) idle(4);
    idle(200);
    checks++;
    if (expq.size() != 0 || pulses != want) begin
      errors++;
      $display("FAIL %s: pulses=%0d queued=%0d required pulses=%0d queued=0", name, pulses, expq.size(), want);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid: got %b required 0", name, valid_o);
    end
    checks++;
    if (packed_out() !== '0) begin
      errors++;
      $display("FAIL %s_data: got %h required 0", name, packed_out());
    end
  endtask

  initial begin
    logic [511:0] inc;
    reset = 1'b0;
    valid_iPin = 1'b0;
    dataPins_i = '0;
    periph_clkPins_i = 2'b10;
    #0.5;
    check_reset_state("reset");
    #0.5;
    reset = 1'b1;
    idle(8);
    send(str_flit("Hello world, this is Flit 0."), 1'b1);
    send(str_flit("This is Flit 1. I love UCIe!"), 1'b1);
    send(str_flit("Flit 2. This is the last one."), 1'b1);
    drain("ascii", 3);
    for (int i = 0; i < 64; i++) inc[8*i +: 8] = 8'(i);
    send(inc, 1'b1);
    drain("incrementing", 4);
    for (int u = 0; u <= 20; u++) ui(1'b1, 16'h5555);
    idle(3);
    send(fill(8'hA5), 1'b1);
    drain("partial_drop", 5);
    run = 1'b0;
    idle(60);
    for (int k = 0; k < DEPTH + 2; k++) send(fill(8'(8'h10 + k)), k < DEPTH);
    idle(20);
    run = 1'b1;
    drain("overflow", 5 + DEPTH);
    run = 1'b0;
    idle(60);
    send(fill(8'h33), 1'b0);
    for (int u = 0; u < 10; u++) ui(1'b1, 16'h7777);
    reset = 1'b0;
    ui(1'b1, 16'h7777);
    check_reset_state("mid_reset");
    for (int u = 11; u < 32; u++) ui(1'b1, 16'h7777);
    idle(8);
    reset = 1'b1;
    idle(8);
    run = 1'b1;
    idle(40);
    send(fill(8'h5A), 1'b1);
    drain("after_reset", 6 + DEPTH);
    idle(40000);
    checks++;
    if (pulses != 6 + DEPTH) begin
      errors++;
      $display("FAIL idle: pulses=%0d required %0d", pulses, 6 + DEPTH);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
